sun_bank: RTL and testbench



---
 rtl/sun_bank_if.sv | 17 +
 rtl/sun_bank.sv | 126 ++++++++++++
 tb/tb_sun_bank.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sun_bank_if.sv
// sun_bank_if: purchase handshake between the plant shop (master) and the
// sun bank (slave).
//   spend_req   master->slave  level, held until spend_done
//   spend_cost  master->slave  16-bit cost, stable while spend_req=1
//   spend_done  slave->master  one-cycle response pulse
//   spend_ok    slave->master  valid with spend_done; 1 = granted
interface sun_bank_if;
  logic        spend_req;
  logic [15:0] spend_cost;
  logic        spend_done;
  logic        spend_ok;

  modport master (output spend_req, output spend_cost,
                  input  spend_done, input spend_ok);
  modport slave  (input  spend_req, input spend_cost,
                  output spend_done, output spend_ok);
endinterface

// File: rtl/sun_bank.sv
// sun_bank: game-state accounting feeding the 8-digit seven-segment scanner.
// Keeps the sun balance and kill score (both saturating at four decimal
// digits), generates passive sun every TICK_CYCLES clocks while running, adds
// collected sun and arbitrates plant purchases over a req/done handshake.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start          pulse: IDLE->RUN, OVER->IDLE
//   game_over      pulse: RUN->OVER (wins over start)
//   collect_pulse  pulse: +COLLECT_AMOUNT sun
//   kill_pulse     pulse: +KILL_POINTS score
//   spend          sun_bank_if.slave purchase handshake
//   sun_count      sun balance 0..SUN_MAX
//   score          kill score 0..SCORE_MAX
//   running        registered (state == RUN)
//   pause          only with SUN_BANK_PAUSE_EN: freezes tick, pulses and
//                  spend acceptance while in RUN; game_over still honoured
//
// Build option: define SUN_BANK_PAUSE_EN to add the pause input.
module sun_bank #(
  parameter int unsigned SUN_START      = 50,
  parameter int unsigned SUN_MAX        = 9999,
  parameter int unsigned SCORE_MAX      = 9999,
  parameter int unsigned TICK_CYCLES    = 100000000,
  parameter int unsigned TICK_AMOUNT    = 25,
  parameter int unsigned COLLECT_AMOUNT = 25,
  parameter int unsigned KILL_POINTS    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        game_over,
  input  logic        collect_pulse,
  input  logic        kill_pulse,
`ifdef SUN_BANK_PAUSE_EN
  input  logic        pause,
`endif
  sun_bank_if.slave   spend,
  output logic [15:0] sun_count,
  output logic [15:0] score,
  output logic        running
);

  localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tick_cnt;
  logic          req_armed;
  logic          paused, active, tick, accept, grant;
  logic [17:0]   sun_sum;
  logic [16:0]   score_sum;
  logic [15:0]   sun_nxt, score_nxt;

`ifdef SUN_BANK_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state; game_over is only looked at in RUN, so it naturally wins
  // over a simultaneous start.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)     state_nxt = S_RUN;
      S_RUN:   if (game_over) state_nxt = S_OVER;
      S_OVER:  if (start)     state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Datapath: every event in a RUN cycle folds into one balance update.
  // Subtract before add is safe because a granted cost never exceeds the
  // balance; 18 bits leave headroom for the sum before saturation.
  always_comb begin
    active    = (state == S_RUN) && !paused;
    tick      = active && (tick_cnt == CW'(TICK_CYCLES - 1));
    accept    = active && spend.spend_req && req_armed;
    grant     = (sun_count >= spend.spend_cost);
    sun_sum   = {2'b00, sun_count}
              - ((accept && grant) ? {2'b00, spend.spend_cost} : 18'd0)
              + (tick ? 18'(TICK_AMOUNT) : 18'd0)
              + ((active && collect_pulse) ? 18'(COLLECT_AMOUNT) : 18'd0);
    sun_nxt   = (sun_sum > 18'(SUN_MAX)) ? 16'(SUN_MAX) : sun_sum[15:0];
    score_sum = {1'b0, score}
              + ((active && kill_pulse) ? 17'(KILL_POINTS) : 17'd0);
    score_nxt = (score_sum > 17'(SCORE_MAX)) ? 16'(SCORE_MAX) : score_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sun_count        <= 16'(SUN_START);
      score            <= '0;
      tick_cnt         <= '0;
      req_armed        <= 1'b1;
      spend.spend_done <= 1'b0;
      spend.spend_ok   <= 1'b0;
      running          <= 1'b0;
    end else begin
      spend.spend_done <= accept;
      spend.spend_ok   <= accept && grant;
      running          <= (state_nxt == S_RUN);
      // One response per request: re-arm only once the requester lets go.
      if (!spend.spend_req) req_armed <= 1'b1;
      else if (accept)      req_armed <= 1'b0;
      if (state == S_IDLE && start) begin
        sun_count <= 16'(SUN_START);
        score     <= '0;
        tick_cnt  <= '0;
      end else if (active) begin
        sun_count <= sun_nxt;
        score     <= score_nxt;
        tick_cnt  <= tick ? '0 : tick_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sun_bank.sv
module tb_sun_bank;
  localparam int TCK = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, game_over = 1'b0;
  logic        collect_pulse = 1'b0, kill_pulse = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] sun_count, score;
  logic        running;

  sun_bank_if bus();

  sun_bank #(.TICK_CYCLES(TCK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .game_over(game_over),
    .collect_pulse(collect_pulse), .kill_pulse(kill_pulse),
`ifdef SUN_BANK_PAUSE_EN
    .pause(pause),
`endif
    .spend(bus.slave), .sun_count(sun_count), .score(score), .running(running)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=idle 1=run 2=over, plain integers.
  int m_mode, m_sun, m_score, m_cnt, m_armed, m_done, m_ok, m_run;
  int n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model();
    bit en, tk, acc, gr;
    if (!rst_n) begin
      m_mode = 0; m_sun = 50; m_score = 0; m_cnt = 0;
      m_armed = 1; m_done = 0; m_ok = 0; m_run = 0;
      return;
    end
    en  = (m_mode == 1) && !pause;
    tk  = en && (m_cnt == TCK - 1);
    acc = en && bus.spend_req && (m_armed != 0);
    gr  = m_sun >= int'(bus.spend_cost);
    m_done = int'(acc);
    m_ok   = int'(acc && gr);
    if (!bus.spend_req) m_armed = 1;
    else if (acc)       m_armed = 0;
    case (m_mode)
      0: if (start) begin m_mode = 1; m_sun = 50; m_score = 0; m_cnt = 0; end
      1: begin
        if (en) begin
          m_sun = min_i(m_sun - ((acc && gr) ? int'(bus.spend_cost) : 0)
                        + (tk ? 25 : 0) + (collect_pulse ? 25 : 0), 9999);
          m_score = min_i(m_score + (kill_pulse ? 10 : 0), 9999);
          m_cnt = (m_cnt + 1) % TCK;
        end
        if (game_over) m_mode = 2;
      end
      default: if (start) m_mode = 0;
    endcase
    m_run = int'(m_mode == 1);
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("sun", sun_count, m_sun);
    chk("score", score, m_score);
    chk("done", bus.spend_done, m_done);
    chk("ok", bus.spend_ok, m_ok);
    chk("running", running, m_run);
  endtask

  task automatic idle();
    start = 0; game_over = 0; collect_pulse = 0; kill_pulse = 0;
  endtask

  // From RUN: over, idle, run again (fresh balance, counter at 0).
  task automatic restart();
    idle(); game_over = 1; step();
    idle(); start = 1; step();
    step();
    idle();
  endtask

  // Raise a request, wait (bounded) for its response, then release.
  task automatic spend(input int c);
    int k;
    bus.spend_req = 1; bus.spend_cost = 16'(c);
    k = 0;
    do begin step(); k++; end while (!m_done && k < 50);
    chk("spend_resp", int'(bus.spend_done), 1);
    bus.spend_req = 0;
    step();
  endtask

  initial begin
    int nd, k;
    bus.spend_req = 0; bus.spend_cost = '0;
    // reset
    rst_n = 0; step(); step();
    chk("rst_sun", sun_count, 50);
    chk("rst_score", score, 0);
    chk("rst_run", running, 0);
    rst_n = 1; step();

    // passive ticks
    start = 1; step(); idle();
    chk("run", running, 1);
    for (int i = 1; i <= 24; i++) begin
      step();
      if (i % 8 == 0) chk("tick_sun", sun_count, 50 + 25 * (i / 8));
    end

    // grant to zero, then denied
    restart();
    bus.spend_req = 1; bus.spend_cost = 16'd50; step();
    chk("g_done", bus.spend_done, 1); chk("g_ok", bus.spend_ok, 1);
    chk("g_sun", sun_count, 0);
    bus.spend_req = 0; step();
    bus.spend_req = 1; bus.spend_cost = 16'd25; step();
    chk("d_done", bus.spend_done, 1); chk("d_ok", bus.spend_ok, 0);
    chk("d_sun", sun_count, 0);
    bus.spend_req = 0; step();

    // held request: one response only (one tick lands inside the window)
    restart();
    collect_pulse = 1; step(); step(); idle();
    nd = 0;
    bus.spend_req = 1; bus.spend_cost = 16'd10;
    for (int i = 0; i < 10; i++) begin step(); nd += int'(bus.spend_done); end
    bus.spend_req = 0; step();
    chk("hold_ndone", nd, 1);
    chk("hold_sun", sun_count, 100 - 10 + 25);

    // saturation
    collect_pulse = 1;
    k = 0;
    while (m_sun != 9999 && k < 1000) begin step(); k++; end
    idle();
    k = 0;
    while (m_sun != 9990 && k < 6) begin spend(9); k++; end
    chk("preload", sun_count, 9990);
    k = 0;
    while (m_cnt != TCK - 1 && k < 20) begin step(); k++; end
    collect_pulse = 1; step(); idle();
    chk("sat_sun", sun_count, 9999);
    kill_pulse = 1;
    for (int i = 0; i < 1000; i++) step();
    idle();
    chk("sat_score", score, 9999);

    // combined spend + collect + tick, then game over
    restart();
    collect_pulse = 1; step(); step(); idle();
    k = 0;
    while (m_cnt != TCK - 1 && k < 20) begin step(); k++; end
    bus.spend_req = 1; bus.spend_cost = 16'd100; collect_pulse = 1; step(); idle();
    chk("comb_sun", sun_count, 50); chk("comb_ok", bus.spend_ok, 1);
    bus.spend_req = 0;
    kill_pulse = 1; step(); idle();
    game_over = 1; start = 1; step(); idle();
    chk("over_run", running, 0);
    collect_pulse = 1; kill_pulse = 1; step(); step(); idle();
    chk("over_sun", sun_count, 50);
    chk("over_score", score, 10);
    start = 1; step(); step(); idle();
    chk("rerun", running, 1); chk("rerun_score", score, 0);
    chk("rerun_sun", sun_count, 50);

`ifdef SUN_BANK_PAUSE_EN
    restart();
    step(); step(); step();
    pause = 1; bus.spend_req = 1; bus.spend_cost = 16'd10; collect_pulse = 1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin step(); nd += int'(bus.spend_done); end
    collect_pulse = 0;
    chk("pause_ndone", nd, 0);
    chk("pause_sun", sun_count, 50);
    pause = 0; step();
    chk("resume_done", bus.spend_done, 1);
    bus.spend_req = 0;
    for (int i = 0; i < 4; i++) step();
    chk("resume_tick", sun_count, 65);
`endif

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      rst_n         = ($urandom_range(0, 399) != 0);
      start         = ($urandom_range(0, 59) == 0);
      game_over     = ($urandom_range(0, 99) == 0);
      collect_pulse = ($urandom_range(0, 3) == 0);
      kill_pulse    = ($urandom_range(0, 3) == 0);
`ifdef SUN_BANK_PAUSE_EN
      pause         = ($urandom_range(0, 7) == 0);
`endif
      if (bus.spend_req && m_done != 0) bus.spend_req = 0;
      else if (!bus.spend_req && $urandom_range(0, 2) == 0) begin
        bus.spend_req = 1;
        case ($urandom_range(0, 3))
          0: bus.spend_cost = 16'd0;
          1: bus.spend_cost = 16'(m_sun);
          default: bus.spend_cost = 16'($urandom_range(0, 300));
        endcase
      end
      step();
    end
    rst_n = 1; idle(); bus.spend_req = 0; pause = 0; step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
